// File: rtl/avalon_speaker_interface.sv
// Avalon-MM playback buffer feeding an I2S master transmitter (sck, ws, sd).
// Stereo words are packed {left, right}, left in the upper half.
module avalon_speaker_interface #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 16,
    parameter int CLK_DIV = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        AVL_READ,
    input  logic        AVL_WRITE,
    input  logic        AVL_CS,
    input  logic [2:0]  AVL_ADDR,
    input  logic [31:0] AVL_WRITEDATA,
    output logic [31:0] AVL_READDATA,
    output logic        sck,
    output logic        ws,
    output logic        sd
);
    localparam int FW = 2 * WIDTH;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(FW);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FW - 1);
    localparam logic [BW-1:0] BIT_HALF = BW'(WIDTH);
    localparam logic [7:0]    LVL_FULL = 8'(DEPTH);

    logic [FW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]    level_q, level_d;
    logic          enable_q, enable_d;
    logic          underrun_q, underrun_d;
    logic          overflow_q, overflow_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          sck_q, sck_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [FW-1:0] shift_q, shift_d;
    logic          sd_q, sd_d;

    logic wr, ctrl_wr, data_wr, flush_wr;
    logic run, tick, pop_slot, pop, push, empty, full;
    logic [31:0] status;

    always_comb begin
        wr       = AVL_WRITE && AVL_CS;
        ctrl_wr  = wr && (AVL_ADDR == 3'd0);
        data_wr  = wr && (AVL_ADDR == 3'd1);
        flush_wr = wr && (AVL_ADDR == 3'd2);
        empty    = (level_q == 8'd0);
        full     = (level_q == LVL_FULL);
        enable_d = ctrl_wr ? AVL_WRITEDATA[0] : enable_q;
        // Serializer runs only while enabled both before and after this edge
        run      = enable_q && enable_d;
        tick     = run && sck_q && (div_cnt_q == DIV_LAST);
        pop_slot = tick && (bit_cnt_q == BIT_LAST);
        pop      = pop_slot && !empty;
        push     = data_wr && !full;

        div_cnt_d = div_cnt_q;
        sck_d     = sck_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        sd_d      = sd_q;
        if (!run) begin
            div_cnt_d = '0;
            sck_d     = 1'b0;
            bit_cnt_d = BIT_LAST;
            shift_d   = '0;
            sd_d      = 1'b0;
        end else begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = '0;
                sck_d     = ~sck_q;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
            if (tick) begin
                bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
                sd_d      = shift_q[FW-1];
                if (pop_slot) begin
                    shift_d = pop ? mem_q[rd_ptr_q] : '0;
                end else begin
                    shift_d = {shift_q[FW-2:0], 1'b0};
                end
            end
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_wr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            level_d = level_q + 8'(push) - 8'(pop);
        end

        // A new event beats a clear landing in the same cycle
        underrun_d = (underrun_q && !(ctrl_wr && AVL_WRITEDATA[3]))
                     || (pop_slot && empty);
        overflow_d = (overflow_q && !(ctrl_wr && AVL_WRITEDATA[4]))
                     || (data_wr && full);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            enable_q   <= 1'b0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
            div_cnt_q  <= '0;
            sck_q      <= 1'b0;
            bit_cnt_q  <= BIT_LAST;
            shift_q    <= '0;
            sd_q       <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            enable_q   <= enable_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
            div_cnt_q  <= div_cnt_d;
            sck_q      <= sck_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            sd_q       <= sd_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {AVL_WRITEDATA[WIDTH+15:16],
                                AVL_WRITEDATA[WIDTH-1:0]};
        end
    end

    assign status = {16'h0, level_q, 3'b000, overflow_q, underrun_q,
                     enable_q, full, empty};
    assign AVL_READDATA = (AVL_READ && AVL_CS && AVL_ADDR == 3'd0)
                          ? status : 32'h0;
    assign sck = sck_q;
    assign ws  = enable_q && (bit_cnt_q >= BIT_HALF);
    assign sd  = sd_q;
endmodule

// File: tb/tb_avalon_speaker_interface.sv
// Directed bench for avalon_speaker_interface: register access, I2S framing,
// underrun/overflow, flush, disable and mid-frame reset.
module tb_avalon_speaker_interface;
    localparam int WIDTH   = 16;
    localparam int DEPTH   = 8;
    localparam int CLK_DIV = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        AVL_READ = 1'b0;
    logic        AVL_WRITE = 1'b0;
    logic        AVL_CS = 1'b0;
    logic [2:0]  AVL_ADDR = 3'd0;
    logic [31:0] AVL_WRITEDATA = 32'h0;
    logic [31:0] AVL_READDATA;
    logic        sck, ws, sd;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb [$];

    avalon_speaker_interface #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .CLK_DIV(CLK_DIV)
    ) dut (
        .CLK(CLK), .RST(RST),
        .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE), .AVL_CS(AVL_CS),
        .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
        .AVL_READDATA(AVL_READDATA),
        .sck(sck), .ws(ws), .sd(sd)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic avl_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge CLK);
        AVL_WRITE = 1'b1; AVL_CS = 1'b1; AVL_ADDR = a; AVL_WRITEDATA = d;
        @(negedge CLK);
        AVL_WRITE = 1'b0; AVL_CS = 1'b0; AVL_ADDR = 3'd0;
    endtask

    task automatic avl_read(input logic [2:0] a, output logic [31:0] d);
        AVL_READ = 1'b1; AVL_CS = 1'b1; AVL_ADDR = a;
        #1 d = AVL_READDATA;
        AVL_READ = 1'b0; AVL_CS = 1'b0; AVL_ADDR = 3'd0;
    endtask

    task automatic wait_rise();
        int n = 0;
        while (sck !== 1'b0 && n < 100) begin @(negedge CLK); n++; end
        while (sck !== 1'b1 && n < 100) begin @(negedge CLK); n++; end
        chk1("sck_rise_timeout", n < 100, 1'b1);
    endtask

    task automatic wait_tick();
        int n = 0;
        while (ws !== 1'b0 && n < 600) begin @(negedge CLK); n++; end
        chk1("tick_timeout", n < 600, 1'b1);
    endtask

    task automatic collect(output logic [31:0] w, output logic [31:0] m);
        w = '0;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            wait_rise();
            w = {w[30:0], sd};
            m = {m[30:0], ws};
        end
    endtask

    initial begin
        logic [31:0] s, w, m, exp;
        logic acc;

        repeat (2) @(negedge CLK);
        RST = 1'b0;
        chk1("rst_sck", sck, 1'b0);
        chk1("rst_ws", ws, 1'b0);
        chk1("rst_sd", sd, 1'b0);
        chk("rst_readdata_idle", AVL_READDATA, 32'h0);
        avl_read(3'd0, s);
        chk("rst_status", s, 32'h0000_0001);
        avl_read(3'd1, s);
        chk("read_addr1_zero", s, 32'h0);

        // single frame
        avl_write(3'd1, 32'hA5A5_0F0F);
        sb.push_back(32'hA5A5_0F0F);
        avl_read(3'd0, s);
        chk("push_status", s, 32'h0000_0100);
        avl_write(3'd0, 32'h1);
        chk1("en_sck0", sck, 1'b0);
        chk1("en_ws1", ws, 1'b1);
        chk1("en_sd0", sd, 1'b0);
        repeat (3) @(negedge CLK);
        chk1("t3_sck_low", sck, 1'b0);
        @(negedge CLK);
        chk1("t4_sck_rise", sck, 1'b1);
        repeat (3) @(negedge CLK);
        chk1("t7_ws_high", ws, 1'b1);
        @(negedge CLK);
        chk1("t8_tick_ws", ws, 1'b0);
        chk1("t8_tick_sck", sck, 1'b0);
        avl_read(3'd0, s);
        chk("after_pop_status", s, 32'h0000_0005);
        wait_rise();
        collect(w, m);
        chk("frame_word", w, sb.pop_front());
        chk("frame_ws", m, 32'h0001_FFFE);

        // underrun
        avl_write(3'd0, 32'h0);
        avl_write(3'd0, 32'h18);
        avl_write(3'd0, 32'h1);
        wait_tick();
        acc = 1'b0;
        for (int i = 0; i < 240; i++) begin
            @(negedge CLK);
            acc = acc | sd;
        end
        chk1("underrun_sd_zero", acc, 1'b0);
        avl_read(3'd0, s);
        chk("underrun_status", s, 32'h0000_000D);
        avl_write(3'd0, 32'h9);
        avl_read(3'd0, s);
        chk("underrun_clear", s, 32'h0000_0005);

        // overflow
        avl_write(3'd0, 32'h0);
        avl_write(3'd0, 32'h18);
        avl_read(3'd0, s);
        chk("idle_status", s, 32'h0000_0001);
        for (int k = 0; k < 9; k++) begin
            w = 32'h9E37_79B9 * 32'(k + 1);
            avl_write(3'd1, w);
            if (sb.size() < DEPTH) sb.push_back(w);
        end
        avl_read(3'd0, s);
        chk("overflow_status", s, 32'h0000_0812);
        avl_write(3'd0, 32'h1);
        wait_tick();
        wait_rise();
        for (int k = 0; k < DEPTH; k++) begin
            collect(w, m);
            exp = sb.pop_front();
            chk($sformatf("ovf_word%0d", k), w, exp);
        end
        collect(w, m);
        chk("ovf_silence", w, 32'h0);
        avl_read(3'd0, s);
        chk("ovf_underrun_bit", s & 32'h8, 32'h8);

        // flush and mid-frame disable
        avl_write(3'd0, 32'h0);
        avl_write(3'd0, 32'h18);
        for (int k = 0; k < 3; k++) avl_write(3'd1, 32'h1111_1111 * 32'(k + 1));
        avl_read(3'd0, s);
        chk("three_queued", s, 32'h0000_0300);
        avl_write(3'd2, 32'hDEAD_BEEF);
        avl_read(3'd0, s);
        chk("flush_status", s, 32'h0000_0001);
        avl_write(3'd1, 32'hFFFF_FFFF);
        avl_write(3'd0, 32'h1);
        wait_tick();
        wait_rise();
        repeat (20) wait_rise();
        chk1("slot20_ws", ws, 1'b1);
        chk1("slot20_sd", sd, 1'b1);
        avl_write(3'd0, 32'h0);
        chk1("dis_sck", sck, 1'b0);
        chk1("dis_ws", ws, 1'b0);
        chk1("dis_sd", sd, 1'b0);
        avl_read(3'd0, s);
        chk("dis_status", s, 32'h0000_0001);

        // reset mid-frame
        for (int k = 0; k < 4; k++) avl_write(3'd1, 32'hFFFF_0000 | 32'(k));
        avl_write(3'd0, 32'h1);
        wait_tick();
        wait_rise();
        repeat (10) wait_rise();
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk1("mid_rst_sck", sck, 1'b0);
        chk1("mid_rst_ws", ws, 1'b0);
        chk1("mid_rst_sd", sd, 1'b0);
        avl_read(3'd0, s);
        chk("mid_rst_status", s, 32'h0000_0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/avalon_speaker_interface.md
# avalon_speaker_interface

Avalon-MM slave that buffers stereo PCM samples written by the HPS/Nios and serializes them as an I2S master transmitter (sck, ws, sd) toward a DAC or amplifier. It is the playback counterpart of the microphone capture path. It shares the same Avalon register style and the same `{left, right}` 32-bit sample packing, with left in the upper half. sck is derived from CLK, so the whole block runs in one clock domain.

## Interface
- WIDTH, 16: bits per channel; legal range 8..16.
- DEPTH, 16: FIFO depth in stereo words; legal range 2..255.
- CLK_DIV, 8: CLK cycles per sck half-period; minimum 2.

- CLK  in  1  system clock.
- RST  in  1  reset; synchronous, active-high.
- AVL_READ  in  1  Avalon-MM read.
- AVL_WRITE  in  1  Avalon-MM write.
- AVL_CS  in  1  chip select.
- AVL_ADDR  in  3  register address.
- AVL_WRITEDATA  in  32  write data.
- AVL_READDATA  out  32  read data.
- sck  out  1  I2S bit clock.
- ws  out  1  I2S word select; 0 = left, 1 = right.
- sd  out  1  I2S serial data, MSB first.

## Operation
- Register map:
  - Addr 0 read, STATUS:
    - bit0: empty.
    - bit1: full.
    - bit2: enable.
    - bit3: underrun (sticky).
    - bit4: overflow (sticky).
    - bits[15:8]: FIFO level.
    - All other bits 0.
  - Addr 0 write, CONTROL:
    - bit0 loads enable.
    - bit3 = 1 clears underrun.
    - bit4 = 1 clears overflow.
  - Addr 1 write, DATA: pushes the sample. Left = WRITEDATA[WIDTH+15:16], right = WRITEDATA[WIDTH-1:0]; other bits are ignored.
  - Addr 2 write, FLUSH: empties the FIFO; the data value is ignored.
  - Reads of addr 1..7 return 0. Writes to addr 3..7 are ignored.
- AVL_READDATA is combinational. It shows the register value when AVL_READ && AVL_CS, and 0 otherwise. Reads have no side effects.
- A write takes effect only when AVL_WRITE && AVL_CS.
- A push when the FIFO is full is discarded and sets overflow. This holds even if a pop occurs in the same cycle.
- The FIFO accepts pushes while disabled, so software can pre-fill it.
- Serializer, when enabled:
  - div_cnt counts 0..CLK_DIV-1. sck toggles when div_cnt = CLK_DIV-1.
  - Each sck 1→0 transition is a tick. On each tick, bit_cnt advances modulo 2·WIDTH.
  - ws = (bit_cnt ≥ WIDTH).
  - On the tick entering slot 0, the block pops one word, as a single-cycle pop.
  - The popped word's MSB-first bits {left, right} occupy slots 1..2·WIDTH-1 plus slot 0 of the next frame. This is the standard I2S one-bit delay.
  - sd changes only on ticks; receivers sample sd on sck rising edges.
- Underrun: if the FIFO is empty at the pop tick, the frame transmits all zeros and underrun is set.
  - If a push and that pop happen in the same cycle on an empty FIFO, the pop still sees empty. The pushed word stays in the FIFO.
- Enable 0→1 (CONTROL write):
  - Next cycle: div_cnt = 0, sck = 0, bit_cnt = 2·WIDTH-1, ws = 1.
  - The transmit shift register is cleared, so sd = 0.
- Enable 1→0:
  - Next cycle: sck, ws and sd are forced to 0 and the counters are reset.
  - The word in flight is discarded; FIFO contents are kept.
- FLUSH while enabled does not disturb the word currently being shifted out.
- Reset values:
  - sck = 0, ws = 0, sd = 0, AVL_READDATA = 0.
  - enable = 0, FIFO empty, stickies = 0, so STATUS = 0x00000001.
  - RST asserted mid-frame returns the block to the reset state on the next CLK edge.

## Timing
- sck period = 2·CLK_DIV CLK cycles. Frame = 2·WIDTH sck periods.
- Measured from the cycle after the enable write:
  - First sck rise at CLK_DIV cycles.
  - First tick (ws→0, pop) at 2·CLK_DIV cycles.
  - Slot 1 (MSB of left on sd) begins at 4·CLK_DIV cycles.
- Push or flush: STATUS reflects it on the cycle after the write.
- Pop: level decrements on the cycle after the tick.
- Simultaneous push and pop on a non-full, non-empty FIFO leaves the level unchanged.
- Sticky bits:
  - They set on the cycle after the event.
  - If a clear write and a new event land in the same cycle, set wins.

## Test plan
Bench parameters: WIDTH=16, DEPTH=8, CLK_DIV=4.

- Reset: pulse RST → sck/ws/sd = 0; STATUS reads 0x00000001.
- Single frame: write 0xA5A50F0F to addr 1, then 0x1 to addr 0.
  - First tick falls 8 cycles after enable.
  - sd sampled on the 32 sck rises of slots 1..31 and next-frame slot 0 reconstructs 0xA5A50F0F.
  - ws is low for slots 0..15. STATUS level is 0 after the pop.
- Underrun: enable with an empty FIFO.
  - sd stays 0 for the entire frame; STATUS bit3 = 1.
  - Writing 0x9 to addr 0 clears bit3 and keeps enable set.
- Overflow: while disabled, write 9 distinct words.
  - STATUS = 0x00000812.
  - Enabling transmits exactly the first 8 words in order, then silence with underrun set.
- Flush and disable: with 3 words queued, write addr 2.
  - STATUS then shows level 0 and empty.
  - Writing 0x0 to addr 0 mid-frame forces sck/ws/sd to 0 on the next cycle.
- Reset mid-frame: assert RST for 1 cycle during slot 10 with 4 words queued.
  - Next cycle all outputs are 0 and STATUS = 0x00000001.
